// File: rtl/lpm_mem_arbiter.sv
// rtl/lpm_mem_arbiter.sv - round-robin arbiter sharing one LPM table memory port among NUM_REQ requesters
// Optional issue/stall counters are built when LPM_ARB_STATS_EN is defined.
module lpm_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_read__ENA,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_read_addr,
  output logic [NUM_REQ-1:0]               req_read__RDY,
  input  logic [NUM_REQ-1:0]               req_write__ENA,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_write_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_write_data,
  output logic [NUM_REQ-1:0]               req_write__RDY,
  output logic                             mem_read__ENA,
  output logic [ADDR_WIDTH-1:0]            mem_read_addr,
  input  logic                             mem_read__RDY,
  output logic                             mem_write__ENA,
  output logic [ADDR_WIDTH-1:0]            mem_write_addr,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic                             mem_write__RDY
`ifdef LPM_ARB_STATS_EN
  ,
  output logic [31:0]                      stat_reads,
  output logic [31:0]                      stat_writes,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    slot_valid;
  logic [NUM_REQ-1:0]    slot_is_write;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];

  logic                  out_valid;
  logic                  out_is_write;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic                  grant_found;
  logic                  consumed;
  logic                  load;

  // Readiness depends only on registered slot state, so a slot freed by a grant refills next cycle.
  assign req_read__RDY  = ~slot_valid;
  assign req_write__RDY = ~slot_valid & ~req_read__ENA;

  assign mem_read__ENA  = out_valid & ~out_is_write;
  assign mem_write__ENA = out_valid & out_is_write;
  assign mem_read_addr  = mem_read__ENA  ? out_addr : '0;
  assign mem_write_addr = mem_write__ENA ? out_addr : '0;
  assign mem_write_data = mem_write__ENA ? out_data : '0;

  assign consumed = (mem_read__ENA & mem_read__RDY) | (mem_write__ENA & mem_write__RDY);
  assign load     = ~out_valid | consumed;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && slot_valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid    <= '0;
      slot_is_write <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
      out_valid    <= 1'b0;
      out_is_write <= 1'b0;
      out_addr     <= '0;
      out_data     <= '0;
      ptr          <= '0;
    end else begin
      if (load) begin
        if (grant_found) begin
          out_valid    <= 1'b1;
          out_is_write <= slot_is_write[grant_idx];
          out_addr     <= slot_addr[grant_idx];
          out_data     <= slot_data[grant_idx];
          ptr          <= ptr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
      // A granted slot is always valid, so it can never be accepting on the same edge.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load && grant_found && grant_idx == PTR_W'(i)) begin
          slot_valid[i] <= 1'b0;
        end else if (req_read__ENA[i] && req_read__RDY[i]) begin
          slot_valid[i]    <= 1'b1;
          slot_is_write[i] <= 1'b0;
          slot_addr[i]     <= req_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else if (req_write__ENA[i] && req_write__RDY[i]) begin
          slot_valid[i]    <= 1'b1;
          slot_is_write[i] <= 1'b1;
          slot_addr[i]     <= req_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data[i]     <= req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef LPM_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (mem_read__ENA && mem_read__RDY) stat_reads <= stat_reads + 32'd1;
      if (mem_write__ENA && mem_write__RDY) stat_writes <= stat_writes + 32'd1;
      if (out_valid && !consumed) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpm_mem_arbiter.sv
// tb/tb_lpm_mem_arbiter.sv - scoreboard bench for lpm_mem_arbiter
module tb_lpm_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NR-1:0]       req_read__ENA;
  logic [NR*AW-1:0]    req_read_addr;
  logic [NR-1:0]       req_read__RDY;
  logic [NR-1:0]       req_write__ENA;
  logic [NR*AW-1:0]    req_write_addr;
  logic [NR*DW-1:0]    req_write_data;
  logic [NR-1:0]       req_write__RDY;
  logic                mem_read__ENA;
  logic [AW-1:0]       mem_read_addr;
  logic                mem_read__RDY;
  logic                mem_write__ENA;
  logic [AW-1:0]       mem_write_addr;
  logic [DW-1:0]       mem_write_data;
  logic                mem_write__RDY;
`ifdef LPM_ARB_STATS_EN
  logic [31:0]         stat_reads;
  logic [31:0]         stat_writes;
  logic [31:0]         stat_stalls;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  cmd_t sb[$];

  lpm_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_read__ENA  (req_read__ENA),
    .req_read_addr  (req_read_addr),
    .req_read__RDY  (req_read__RDY),
    .req_write__ENA (req_write__ENA),
    .req_write_addr (req_write_addr),
    .req_write_data (req_write_data),
    .req_write__RDY (req_write__RDY),
    .mem_read__ENA  (mem_read__ENA),
    .mem_read_addr  (mem_read_addr),
    .mem_read__RDY  (mem_read__RDY),
    .mem_write__ENA (mem_write__ENA),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_write__RDY (mem_write__RDY)
`ifdef LPM_ARB_STATS_EN
    ,
    .stat_reads     (stat_reads),
    .stat_writes    (stat_writes),
    .stat_stalls    (stat_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfers happen at the next rising edge; judge them at the preceding falling edge.
  always @(negedge CLK) begin
    cmd_t e;
    if (!RST && ((mem_read__ENA && mem_read__RDY) || (mem_write__ENA && mem_write__RDY))) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {62'd0, mem_read__ENA, mem_write__ENA}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", {63'd0, mem_write__ENA}, {63'd0, e.w});
        if (e.w) begin
          check("sb_wr_addr", {32'd0, mem_write_addr}, {32'd0, e.addr});
          check("sb_wr_data", {32'd0, mem_write_data}, {32'd0, e.data});
        end else begin
          check("sb_rd_addr", {32'd0, mem_read_addr}, {32'd0, e.addr});
        end
      end
    end
  end

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t e;
    e.w = w; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    RST            = 1'b1;
    req_read__ENA  = '0;
    req_write__ENA = '0;
    mem_read__RDY  = 1'b1;
    mem_write__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Hold each asserted ENA until its handshake edge, then drop it.
  task automatic accept_wait;
    logic [NR-1:0] ra, wa;
    int n;
    n = 0;
    while ((req_read__ENA | req_write__ENA) != '0 && n < 50) begin
      @(negedge CLK);
      ra = req_read__ENA & req_read__RDY;
      wa = req_write__ENA & req_write__RDY;
      @(posedge CLK);
      #1;
      req_read__ENA  = req_read__ENA & ~ra;
      req_write__ENA = req_write__ENA & ~wa;
      n++;
    end
    check("accept_timeout", {60'd0, req_read__ENA, req_write__ENA}, 64'd0);
    req_read__ENA  = '0;
    req_write__ENA = '0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST            = 1'b1;
    req_read__ENA  = '0;
    req_write__ENA = '0;
    req_read_addr  = '0;
    req_write_addr = '0;
    req_write_data = '0;
    mem_read__RDY  = 1'b1;
    mem_write__RDY = 1'b1;
    #2;
    check("rst_rd_ena", {63'd0, mem_read__ENA}, 64'd0);
    check("rst_wr_ena", {63'd0, mem_write__ENA}, 64'd0);
    check("rst_rd_rdy", {62'd0, req_read__RDY}, 64'd3);
    check("rst_wr_rdy", {62'd0, req_write__RDY}, 64'd3);
    check("rst_addr", {mem_read_addr, mem_write_addr}, 64'd0);
    check("rst_data", {32'd0, mem_write_data}, 64'd0);

    // single read, two-edge latency, one-cycle ENA
    do_reset;
    req_read_addr[0 +: AW] = 32'h10;
    req_read__ENA = 2'b01;
    push(1'b0, 32'h10, '0);
    @(posedge CLK); #1 req_read__ENA = '0;
    @(negedge CLK);
    check("sr_rdy_busy", {63'd0, req_read__RDY[0]}, 64'd0);
    check("sr_ena_early", {63'd0, mem_read__ENA}, 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("sr_rdy_back", {63'd0, req_read__RDY[0]}, 64'd1);
    check("sr_ena", {63'd0, mem_read__ENA}, 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    check("sr_ena_once", {63'd0, mem_read__ENA}, 64'd0);
    wait_drain;

    // round-robin alternation of back-to-back writes
    do_reset;
    for (int n = 0; n < 4; n++) begin
      push(1'b1, 32'h100 + n, 32'hA0 + n);
      push(1'b1, 32'h200 + n, 32'hB0 + n);
    end
    for (int n = 0; n < 4; n++) begin
      req_write_addr = {32'h200 + 32'(n), 32'h100 + 32'(n)};
      req_write_data = {32'hB0 + 32'(n), 32'hA0 + 32'(n)};
      req_write__ENA = 2'b11;
      accept_wait;
    end
    wait_drain;

    // memory backpressure with both slots full
    do_reset;
    mem_write__RDY = 1'b0;
    req_write_addr = {32'h40, 32'h30};
    req_write_data = {32'h66, 32'h55};
    req_write__ENA = 2'b11;
    push(1'b1, 32'h30, 32'h55);
    push(1'b1, 32'h40, 32'h66);
    accept_wait;
    req_write_addr[0 +: AW] = 32'h34;
    req_write_data[0 +: DW] = 32'h77;
    req_write__ENA = 2'b01;
    push(1'b1, 32'h34, 32'h77);
    accept_wait;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_ena", {63'd0, mem_write__ENA}, 64'd1);
      check("bp_addr", {32'd0, mem_write_addr}, 64'h30);
      check("bp_data", {32'd0, mem_write_data}, 64'h55);
      check("bp_wr_rdy", {62'd0, req_write__RDY}, 64'd0);
      check("bp_rd_rdy", {62'd0, req_read__RDY}, 64'd0);
      @(posedge CLK);
    end
    #1 mem_write__RDY = 1'b1;
    wait_drain;

    // read and write collide on requester 1
    do_reset;
    req_read_addr[AW +: AW]  = 32'h20;
    req_write_addr[AW +: AW] = 32'h24;
    req_write_data[DW +: DW] = 32'hDEAD;
    req_read__ENA  = 2'b10;
    req_write__ENA = 2'b10;
    push(1'b0, 32'h20, '0);
    push(1'b1, 32'h24, 32'hDEAD);
    #1;
    check("col_wr_rdy", {63'd0, req_write__RDY[1]}, 64'd0);
    check("col_rd_rdy", {63'd0, req_read__RDY[1]}, 64'd1);
    accept_wait;
    wait_drain;

    // asynchronous reset discards slots and the in-flight command
    do_reset;
    mem_read__RDY = 1'b0;
    req_read_addr = {32'h60, 32'h50};
    req_read__ENA = 2'b11;
    accept_wait;
    req_read_addr[0 +: AW] = 32'h54;
    req_read__ENA = 2'b01;
    accept_wait;
    @(negedge CLK);
    check("ar_pre_ena", {63'd0, mem_read__ENA}, 64'd1);
    check("ar_pre_rdy", {62'd0, req_read__RDY}, 64'd0);
    #2 RST = 1'b1;
    #1;
    check("ar_ena", {62'd0, mem_read__ENA, mem_write__ENA}, 64'd0);
    check("ar_rd_rdy", {62'd0, req_read__RDY}, 64'd3);
    check("ar_wr_rdy", {62'd0, req_write__RDY}, 64'd3);
    check("ar_addr", {32'd0, mem_read_addr}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    mem_read__RDY = 1'b1;
    req_read_addr = {32'h80, 32'h70};
    req_read__ENA = 2'b11;
    push(1'b0, 32'h70, '0);
    push(1'b0, 32'h80, '0);
    accept_wait;
    wait_drain;

`ifdef LPM_ARB_STATS_EN
    do_reset;
    mem_read__RDY = 1'b0;
    req_read_addr[0 +: AW] = 32'h300;
    req_read__ENA = 2'b01;
    push(1'b0, 32'h300, '0);
    accept_wait;
    @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1 mem_read__RDY = 1'b1;
    req_read_addr[0 +: AW] = 32'h304;
    req_read__ENA = 2'b01;
    push(1'b0, 32'h304, '0);
    accept_wait;
    req_write_addr[AW +: AW] = 32'h308;
    req_write_data[DW +: DW] = 32'h1;
    req_write__ENA = 2'b10;
    push(1'b1, 32'h308, 32'h1);
    accept_wait;
    req_write_addr[AW +: AW] = 32'h30C;
    req_write_data[DW +: DW] = 32'h2;
    req_write__ENA = 2'b10;
    push(1'b1, 32'h30C, 32'h2);
    accept_wait;
    req_read_addr[0 +: AW] = 32'h310;
    req_read__ENA = 2'b01;
    push(1'b0, 32'h310, '0);
    accept_wait;
    wait_drain;
    check("st_reads", {32'd0, stat_reads}, 64'd3);
    check("st_writes", {32'd0, stat_writes}, 64'd2);
    check("st_stalls", {32'd0, stat_stalls}, 64'd4);
    force dut.stat_reads = 32'hFFFF_FFFF;
    #1 release dut.stat_reads;
    req_read_addr[0 +: AW] = 32'h314;
    req_read__ENA = 2'b01;
    push(1'b0, 32'h314, '0);
    accept_wait;
    wait_drain;
    check("st_wrap", {32'd0, stat_reads}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpm_mem_arbiter.md
Name: lpm_mem_arbiter

Overview:
- Shares one LPM table memory port (read/write methods with ENA/RDY handshake) among NUM_REQ requesters, e.g. lookup engines and the route-update engine.
- Each requester gets a one-entry command slot.
- A round-robin scheduler issues one command per cycle into a registered output stage that drives the memory server port.
- Sits between the requesters' client ports and the single memory server.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, write data width.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- req_read__ENA  in  NUM_REQ  per-requester read request.
- req_read$addr  in  NUM_REQ*ADDR_WIDTH  read address; requester i at slice i.
- req_read__RDY  out  NUM_REQ  read accept-ready.
- req_write__ENA  in  NUM_REQ  per-requester write request.
- req_write$addr  in  NUM_REQ*ADDR_WIDTH  write address.
- req_write$data  in  NUM_REQ*DATA_WIDTH  write data.
- req_write__RDY  out  NUM_REQ  write accept-ready.
- mem_read__ENA  out  1  read issue to memory.
- mem_read$addr  out  ADDR_WIDTH  read address.
- mem_read__RDY  in  1  memory can take a read.
- mem_write__ENA  out  1  write issue to memory.
- mem_write$addr  out  ADDR_WIDTH  write address.
- mem_write$data  out  DATA_WIDTH  write data.
- mem_write__RDY  in  1  memory can take a write.
- stat_reads  out  32  issued-read count (LPM_ARB_STATS_EN only).
- stat_writes  out  32  issued-write count (LPM_ARB_STATS_EN only).
- stat_stalls  out  32  stall-cycle count (LPM_ARB_STATS_EN only).

Behaviour:
- Clocking and reset: one clock, CLK. RST is asynchronous and active-high; it is applied without waiting for a CLK edge.
- Handshake: a transfer occurs on a rising CLK edge where ENA && RDY. ENA is never gated by RDY on the request side.
- Requester slot i holds: valid, is_write, addr, data.
  - req_read__RDY[i] = !slot_valid[i].
  - req_write__RDY[i] = !slot_valid[i] && !req_read__ENA[i]. When both are asserted, the read wins and the write waits.
- Slot capture: an accepted command is stored at the edge and slot_valid[i] is set.
- Output stage: register holds out_valid, out_is_write, out_addr, out_data.
  - mem_read__ENA = out_valid && !out_is_write.
  - mem_write__ENA = out_valid && out_is_write.
  - Address and data come straight from the register. Values are don't-care while ENA is low, but are driven as zero.
- Output consumed when (mem_read__ENA && mem_read__RDY) || (mem_write__ENA && mem_write__RDY).
- Load condition: load = !out_valid || consumed.
- Grant: on a load cycle with any slot valid, pick the first valid slot searching from ptr upward, modulo NUM_REQ. Copy it into the output register, clear that slot, then set ptr = grant+1 (wrapping NUM_REQ-1 -> 0).
- A slot cleared by a grant may be refilled on the same edge only from the next cycle: RDY is registered-state based, so no same-cycle refill.
- No load with no valid slot: out_valid <= 0 if consumed, otherwise held.
- Latency: request accepted at edge t -> output register loaded at edge t+1 -> mem ENA high in the cycle after t+1. Minimum 2 edges.
- Throughput: one command per cycle with mem RDY held high.
- Memory backpressure: while mem RDY is low, the output register holds and ENA, addr and data are stable.
- Fairness: with all slots continuously refilled, each requester is granted at least once every NUM_REQ issues.
- Ordering: per requester, strictly in order. Across requesters there is no ordering guarantee.
- Reset values: all slots invalid, out_valid=0, ptr=0, stats=0.
  - Immediately after RST assertion: mem_*__ENA=0, req_*__RDY all 1, mem addr/data = 0.
- Reset mid-operation discards pending slots and the in-flight output command without issuing them.

Optional Feature:
- Macro: LPM_ARB_STATS_EN.
- Enabled: stat_* ports exist.
  - stat_reads increments on each consumed read.
  - stat_writes increments on each consumed write.
  - stat_stalls increments each cycle out_valid && !consumed.
  - All three wrap 0xFFFFFFFF -> 0.
  - All three are cleared by RST.
- Disabled: stat_* ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single read: req 0 read addr 0x10 at edge 1, mem RDY=1 -> mem_read__ENA high for exactly one cycle after edge 2 with addr 0x10; req_read__RDY[0] low for one cycle only.
- Round-robin: both requesters issue back-to-back writes (req0 data 0xA0+n, req1 data 0xB0+n), mem RDY=1 -> memory sees a strictly alternating sequence 0xA0, 0xB0, 0xA1, 0xB1..., starting with req0.
- Backpressure: mem_write__RDY=0 for 5 cycles with a write pending -> ENA/addr/data stable for 5 cycles; issue on the 6th; slots stay full and RDY stays low meanwhile.
- Simultaneous read+write on req 1 -> read 0x20 issued first; write 0x24/0xDEAD issued next; write__RDY[1] low in the collision cycle.
- Async reset: assert RST mid-cycle with out_valid=1 and both slots full -> ENA drops without waiting for a CLK edge, RDY all 1, and the first request after release is granted to req 0.
- With LPM_ARB_STATS_EN: 3 reads, 2 writes, 4 stall cycles -> stat_reads=3, stat_writes=2, stat_stalls=4. Preload-by-force to 0xFFFFFFFF then one read -> stat_reads=0.
